ram_phase_sequencer: RTL

Parametrised owner of the single synchronous RC4 working RAM. It replaces per-mode manual selection with a hardware sequencer: one `start` either runs every attached engine in order (init → shuffle → decrypt …) or runs one selected engine. It issues per-engine start pulses, detects completion, muxes the owning engine onto the RAM port, and flags engines that hang. It sits between the top-level control FSM and the engine instances (`ram_initializer`, `ram_shuffler`, later stages).

---
 rtl/rc4_pkg.sv | 20 ++
 rtl/ram_bus_mux.sv | 24 ++
 rtl/ram_phase_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 working-RAM sequencing logic.
package rc4_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait,
        StDone
    } seq_state_t;

    localparam int unsigned PH_INIT    = 0;
    localparam int unsigned PH_SHUFFLE = 1;
    localparam int unsigned PH_DECRYPT = 2;

    localparam int unsigned DEF_RAM_WIDTH   = 8;
    localparam int unsigned DEF_ADDR_WIDTH  = 8;
    localparam int unsigned DEF_NUM_DEVICES = 3;
    localparam int unsigned DEF_TIMEOUT     = 4096;

endpackage

// File: rtl/ram_bus_mux.sv
// One-of-N combinational selector; output forced to zero when not enabled.
module ram_bus_mux #(
    parameter int unsigned N     = 3,
    parameter int unsigned WIDTH = 17,
    parameter int unsigned SEL_W = 2
) (
    input  logic                      en,
    input  logic [SEL_W-1:0]          sel,
    input  logic [N-1:0][WIDTH-1:0]   din,
    output logic [WIDTH-1:0]          dout
);

    always_comb begin
        dout = '0;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                if (sel == SEL_W'(i)) begin
                    dout = din[i];
                end
            end
        end
    end

endmodule

// File: rtl/ram_phase_sequencer.sv
// Owns the RC4 working RAM: launches engines in order (or one selected engine),
// detects their completion edges, muxes the owner onto the RAM port and times out hangs.
module ram_phase_sequencer
    import rc4_pkg::*;
#(
    parameter int unsigned RAM_WIDTH   = DEF_RAM_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_DEVICES = DEF_NUM_DEVICES,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter int unsigned IDX_W       = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic                                   run_all,
    input  logic [IDX_W-1:0]                       phase_sel,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   error,
    output logic [IDX_W-1:0]                       active_phase,
    output logic [NUM_DEVICES-1:0]                 dev_start,
    input  logic [NUM_DEVICES-1:0]                 dev_finished,
    input  logic [NUM_DEVICES-1:0]                 dev_we,
    input  logic [NUM_DEVICES-1:0][RAM_WIDTH-1:0]  dev_ram_in,
    input  logic [NUM_DEVICES-1:0][ADDR_WIDTH-1:0] dev_address,
    output logic                                   write_enable,
    output logic [RAM_WIDTH-1:0]                   ram_in,
    output logic [ADDR_WIDTH-1:0]                  address
);

    localparam int unsigned WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned LIMIT  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam int unsigned BUS_W  = 1 + RAM_WIDTH + ADDR_WIDTH;

    seq_state_t              state_q;
    logic [IDX_W-1:0]        phase_q;
    logic [WDOG_W-1:0]       wdog_q;
    logic [NUM_DEVICES-1:0]  fin_q;
    logic [NUM_DEVICES-1:0]  dev_start_q;
    logic                    run_all_q;
    logic                    done_q;
    logic                    error_q;

    logic                    fin_edge;
    logic                    sel_ok;
    logic                    last_phase;
    logic                    wdog_expired;
    logic [IDX_W-1:0]        next_phase;

    assign fin_edge     = dev_finished[phase_q] & ~fin_q[phase_q];
    assign sel_ok       = 32'(phase_sel) < NUM_DEVICES;
    assign last_phase   = (phase_q == IDX_W'(NUM_DEVICES - 1));
    assign wdog_expired = (TIMEOUT != 0) && (wdog_q == WDOG_W'(LIMIT));
    assign next_phase   = phase_q + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            phase_q     <= '0;
            wdog_q      <= '0;
            fin_q       <= '0;
            dev_start_q <= '0;
            run_all_q   <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            fin_q       <= dev_finished;
            dev_start_q <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (run_all) begin
                            phase_q     <= '0;
                            run_all_q   <= 1'b1;
                            dev_start_q <= NUM_DEVICES'(1);
                            state_q     <= StLaunch;
                        end else if (sel_ok) begin
                            phase_q     <= phase_sel;
                            run_all_q   <= 1'b0;
                            dev_start_q <= NUM_DEVICES'(1) << phase_sel;
                            state_q     <= StLaunch;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                StLaunch: begin
                    wdog_q  <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (fin_edge) begin
                        if (run_all_q && !last_phase) begin
                            phase_q     <= next_phase;
                            dev_start_q <= NUM_DEVICES'(1) << next_phase;
                            state_q     <= StLaunch;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end else if (wdog_expired) begin
                        // Hung engine: abandon the rest of the run.
                        error_q <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        wdog_q <= wdog_q + WDOG_W'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy         = (state_q != StIdle);
    assign done         = done_q;
    assign error        = error_q;
    assign dev_start    = dev_start_q;
    assign active_phase = phase_q;

    logic [NUM_DEVICES-1:0][BUS_W-1:0] bus_bundle;
    logic [BUS_W-1:0]                  bus_sel;
    logic                              bus_en;

    always_comb begin
        for (int i = 0; i < NUM_DEVICES; i++) begin
            bus_bundle[i] = {dev_we[i], dev_ram_in[i], dev_address[i]};
        end
    end

    assign bus_en = (state_q == StLaunch) || (state_q == StWait);

    ram_bus_mux #(
        .N     (NUM_DEVICES),
        .WIDTH (BUS_W),
        .SEL_W (IDX_W)
    ) u_bus_mux (
        .en   (bus_en),
        .sel  (phase_q),
        .din  (bus_bundle),
        .dout (bus_sel)
    );

    assign {write_enable, ram_in, address} = bus_sel;

endmodule
